// File: rtl/mdu_execute.sv
// Iterative RV32M multiply/divide execute unit: one bit per cycle, fixed 34-cycle
// occupancy, single register-file write-back. Define MDU_DIV_EN to build the divider.
module mdu_execute #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     b_mag;
  // Shared shift register: {acc_hi, acc_lo} is {partial product, multiplier}
  // for multiplies and {partial remainder, dividend/quotient} for divides.
  logic [2*XLEN-1:0]   acc;

  logic                accept, last;
  logic                cap_a_neg, cap_b_neg;
  logic [XLEN-1:0]     a_mag_in, b_mag_in;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_step, prod;
  logic [XLEN-1:0]     mul_res;

  logic [2*XLEN-1:0]   acc_step;
  logic [XLEN-1:0]     result;
  logic                res_upd, res_we, res_err;

`ifdef MDU_DIV_EN
  logic                div_zero;
  logic [XLEN:0]       div_shift;
  logic [XLEN-1:0]     div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   div_step;
  logic [XLEN-1:0]     quo_res, rem_res, div_res;
`endif

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid & in_ready;
  assign last     = (state == S_CALC) && (cnt == CNT_W'(XLEN - 1));

  // Operand signs only matter for the signed flavours; unsigned ops use raw values.
  assign cap_a_neg = (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & rs1_val[XLEN-1];
  assign cap_b_neg = (op inside {OP_MULH, OP_DIV, OP_REM}) & rs2_val[XLEN-1];
  assign a_mag_in  = cap_a_neg ? -rs1_val : rs1_val;
  assign b_mag_in  = cap_b_neg ? -rs2_val : rs2_val;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_CALC;
      S_CALC:  if (last)     state_nxt = S_DONE;
      S_DONE:                state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Shift-add: add multiplicand when the multiplier LSB is set, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    mul_step = {mul_sum, acc[XLEN-1:1]};
    prod     = (a_neg ^ b_neg) ? -mul_step : mul_step;
    mul_res  = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef MDU_DIV_EN
  // Restoring divide: shift the next dividend bit in, subtract when it fits.
  always_comb begin
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_ge    = div_shift >= {1'b0, b_mag};
    div_diff  = div_shift[XLEN-1:0] - b_mag;
    div_step  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    // Divide-by-zero quotient is all ones regardless of sign; the remainder
    // naturally comes out as the dividend.
    quo_res   = div_zero ? '1 :
                ((a_neg ^ b_neg) ? -div_step[XLEN-1:0] : div_step[XLEN-1:0]);
    rem_res   = a_neg ? -div_step[2*XLEN-1:XLEN] : div_step[2*XLEN-1:XLEN];
    div_res   = op_q[1] ? rem_res : quo_res;
    acc_step  = op_q[2] ? div_step : mul_step;
    result    = op_q[2] ? div_res : mul_res;
    res_upd   = 1'b1;
    res_we    = (rd_q != 5'd0);
    res_err   = 1'b0;
  end
`else
  // Divide ops still run the full sequence on the multiply datapath, but their
  // result is discarded and flagged through err instead of being written back.
  always_comb begin
    acc_step = mul_step;
    result   = mul_res;
    res_upd  = ~op_q[2];
    res_we   = (rd_q != 5'd0) & ~op_q[2];
    res_err  = op_q[2];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      b_mag   <= '0;
      acc     <= '0;
`ifdef MDU_DIV_EN
      div_zero <= 1'b0;
`endif
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      op_q    <= op;
      rd_q    <= rd;
      a_neg   <= cap_a_neg;
      b_neg   <= cap_b_neg;
      b_mag   <= b_mag_in;
      acc     <= {{XLEN{1'b0}}, a_mag_in};
`ifdef MDU_DIV_EN
      div_zero <= (rs2_val == '0);
`endif
    end else if (state == S_CALC) begin
      cnt <= cnt + 1'b1;
      acc <= acc_step;
      if (last) begin
        if (res_upd) wb_data <= result;
        wb_addr <= rd_q;
        wb_we   <= res_we;
        err     <= res_err;
      end
    end else if (state == S_DONE) begin
      wb_we <= 1'b0;
      err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdu_execute.sv
// Directed self-checking bench for mdu_execute; follows MDU_DIV_EN to pick
// between divider results and the err pulse for ops 4-7.
`timescale 1ns/1ps
module tb_mdu_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd;
  logic        busy, wb_we, err;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_total = 0;
  int n_pass  = 0;

  mdu_execute dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .rd       (rd),
    .busy     (busy),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and check the exact fixed-latency write-back timing.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                       input bit exp_we, input bit exp_err);
    op = o; rs1_val = a; rs2_val = b; rd = r; in_valid = 1'b1;
    tick();                                  // T0: accept
    in_valid = 1'b0; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678; rd = 5'd31;
    check({tag, ".ready_drop"}, in_ready, 1'b0);
    repeat (31) tick();                      // T31
    check({tag, ".we_early"}, wb_we, 1'b0);
    tick();                                  // T32
    check({tag, ".we"}, wb_we, exp_we);
    check({tag, ".err"}, err, exp_err);
    if (exp_we) begin
      check({tag, ".addr"}, wb_addr, r);
      check({tag, ".data"}, wb_data, exp);
    end
    tick();                                  // T33
    check({tag, ".ready_back"}, in_ready, 1'b1);
    check({tag, ".we_clear"}, wb_we, 1'b0);
    check({tag, ".err_clear"}, err, 1'b0);
  endtask

  initial begin
    int we_seen;
    rst = 1'b0; in_valid = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd = '0;
    #12;
    check("rst.busy", busy, 1'b0);
    check("rst.we", wb_we, 1'b0);
    check("rst.addr", wb_addr, 5'd0);
    check("rst.data", wb_data, 32'd0);
    check("rst.err", err, 1'b0);
    rst = 1'b1;
    tick();
    check("rst.ready", in_ready, 1'b1);

    do_op("mul", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 1'b1, 1'b0);
    check("mul.hold_data", wb_data, 32'd42);
    check("mul.hold_addr", wb_addr, 5'd5);

    do_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, 1'b1, 1'b0);
    do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("mul_neg", 3'd0, 32'hFFFF_FFFD, 32'd5,        5'd9, 32'hFFFF_FFF1, 1'b1, 1'b0);

`ifdef MDU_DIV_EN
    do_op("div",     3'd4, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFA, 1'b1, 1'b0);
    do_op("rem",     3'd6, 32'hFFFF_FFEC, 32'd3, 5'd11, 32'hFFFF_FFFE, 1'b1, 1'b0);
    do_op("divu",    3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 1'b1, 1'b0);
    do_op("remu",    3'd7, 32'd100, 32'd7, 5'd13, 32'd2,  1'b1, 1'b0);
    do_op("divu_z",  3'd5, 32'd55, 32'd0, 5'd14, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("rem_z",   3'd6, 32'd55, 32'd0, 5'd15, 32'd55, 1'b1, 1'b0);
    do_op("div_negz", 3'd4, 32'hFFFF_FFF9, 32'd0, 5'd16, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1'b1, 1'b0);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 1'b1, 1'b0);
`else
    do_op("div_off",  3'd4, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'd0, 1'b0, 1'b1);
    do_op("remu_off", 3'd7, 32'd100, 32'd7, 5'd13, 32'd0, 1'b0, 1'b1);
`endif

    // Second request held high through CALC/DONE must wait for in_ready.
    op = 3'd0; rs1_val = 32'd5; rs2_val = 32'd5; rd = 5'd3; in_valid = 1'b1;
    tick();                                  // T0
    op = 3'd3; rs1_val = 32'h8000_0000; rs2_val = 32'd4; rd = 5'd4;
    repeat (32) tick();                      // T32
    check("b2b.we1", wb_we, 1'b1);
    check("b2b.addr1", wb_addr, 5'd3);
    check("b2b.data1", wb_data, 32'd25);
    tick();                                  // T33
    check("b2b.ready", in_ready, 1'b1);
    tick();                                  // T34: second accept
    check("b2b.accept", in_ready, 1'b0);
    in_valid = 1'b0;
    repeat (32) tick();                      // T66
    check("b2b.we2", wb_we, 1'b1);
    check("b2b.addr2", wb_addr, 5'd4);
    check("b2b.data2", wb_data, 32'd2);
    tick();

    // rd == 0 runs the full sequence without a write strobe.
    op = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9; rd = 5'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 34; i++) begin
      if (wb_we) we_seen++;
      tick();
    end
    check("rd0.no_we", we_seen, 0);
    check("rd0.ready", in_ready, 1'b1);

    // Reset mid-operation discards the result.
    op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3; rd = 5'd7; in_valid = 1'b1;
    tick();                                  // T0
    in_valid = 1'b0;
    repeat (10) tick();                      // cnt == 10
    check("mrst.busy_before", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mrst.busy", busy, 1'b0);
    check("mrst.ready", in_ready, 1'b1);
    check("mrst.we", wb_we, 1'b0);
    check("mrst.data", wb_data, 32'd0);
    #3 rst = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wb_we) we_seen++;
    end
    check("mrst.no_wb", we_seen, 0);
    check("mrst.idle", in_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
